// File: rtl/arith_sequencer.sv
// Multi-cycle control sequencer for a small integer ALU datapath.
// Fetches one instruction per pass, decodes the arithmetic/logic subset, pulses writeback, faults into HALT.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_FETCH  | request instruction, wait for ack, fault after ACK_TIMEOUT
// S_DECODE | legality check on latched opcode/funct
// S_EXEC   | ALU controls valid
// S_WB     | ALU controls valid, register-file write and PC advance
// S_HALT   | sticky fault, absorbing until reset
module arith_sequencer #(
  parameter int unsigned ACK_TIMEOUT = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] inst,
  input  logic        imem_ack,
  output logic        imem_req,
  output logic        pc_enable,
  output logic        rf_write_enable,
  output logic [2:0]  alu_op,
  output logic        alu_src2,
  output logic        rd_src,
  output logic        zero_ext,
  output logic        except,
  output logic [15:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT
  } state_e;

  localparam logic [7:0] WAIT_LOAD = 8'(ACK_TIMEOUT - 1);

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_ANDI  = 6'h0c;
  localparam logic [5:0] OPC_ORI   = 6'h0d;
  localparam logic [5:0] OPC_XORI  = 6'h0e;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_NOR = 6'h27;

  localparam logic [2:0] ALU_ADD = 3'd2;
  localparam logic [2:0] ALU_SUB = 3'd3;
  localparam logic [2:0] ALU_AND = 3'd4;
  localparam logic [2:0] ALU_OR  = 3'd5;
  localparam logic [2:0] ALU_NOR = 3'd6;
  localparam logic [2:0] ALU_XOR = 3'd7;

  state_e      state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic [5:0]  opcode_q, opcode_d;
  logic [5:0]  funct_q, funct_d;
  logic [15:0] retired_q, retired_d;

  logic        dec_legal;
  logic [2:0]  dec_alu_op;
  logic        dec_src2;
  logic        dec_rd_src;
  logic        dec_zext;

  // Register fields between funct and opcode are consumed by the datapath, not here.
  logic unused_inst;
  assign unused_inst = ^inst[25:6];

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_FETCH;
      wait_cnt_q <= WAIT_LOAD;
      opcode_q   <= '0;
      funct_q    <= '0;
      retired_q  <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      opcode_q   <= opcode_d;
      funct_q    <= funct_d;
      retired_q  <= retired_d;
    end
  end

  always_comb begin
    dec_legal  = 1'b0;
    dec_alu_op = 3'd0;
    dec_src2   = 1'b0;
    dec_rd_src = 1'b0;
    dec_zext   = 1'b0;
    if (opcode_q == OPC_RTYPE) begin
      unique case (funct_q)
        FN_ADD:  begin dec_legal = 1'b1; dec_alu_op = ALU_ADD; end
        FN_SUB:  begin dec_legal = 1'b1; dec_alu_op = ALU_SUB; end
        FN_AND:  begin dec_legal = 1'b1; dec_alu_op = ALU_AND; end
        FN_OR:   begin dec_legal = 1'b1; dec_alu_op = ALU_OR;  end
        FN_XOR:  begin dec_legal = 1'b1; dec_alu_op = ALU_XOR; end
        FN_NOR:  begin dec_legal = 1'b1; dec_alu_op = ALU_NOR; end
        default: dec_legal = 1'b0;
      endcase
    end else begin
      dec_src2   = 1'b1;
      dec_rd_src = 1'b1;
      unique case (opcode_q)
        OPC_ADDI: begin dec_legal = 1'b1; dec_alu_op = ALU_ADD; end
        OPC_ANDI: begin dec_legal = 1'b1; dec_alu_op = ALU_AND; dec_zext = 1'b1; end
        OPC_ORI:  begin dec_legal = 1'b1; dec_alu_op = ALU_OR;  dec_zext = 1'b1; end
        OPC_XORI: begin dec_legal = 1'b1; dec_alu_op = ALU_XOR; dec_zext = 1'b1; end
        default:  dec_legal = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    opcode_d   = opcode_q;
    funct_d    = funct_q;
    retired_d  = retired_q;
    unique case (state_q)
      S_FETCH: begin
        // An ack arriving on the terminal wait cycle still completes the fetch.
        if (imem_ack) begin
          opcode_d   = inst[31:26];
          funct_d    = inst[5:0];
          wait_cnt_d = WAIT_LOAD;
          state_d    = S_DECODE;
        end else if (wait_cnt_q == 8'd0) begin
          state_d = S_HALT;
        end else begin
          wait_cnt_d = wait_cnt_q - 8'd1;
        end
      end
      S_DECODE: state_d = dec_legal ? S_EXEC : S_HALT;
      S_EXEC:   state_d = S_WB;
      S_WB: begin
        retired_d  = retired_q + 16'd1;
        wait_cnt_d = WAIT_LOAD;
        state_d    = S_FETCH;
      end
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH;
    endcase
  end

  // Outputs are held idle while reset is asserted so no write pulse escapes mid-reset.
  always_comb begin
    imem_req        = 1'b0;
    pc_enable       = 1'b0;
    rf_write_enable = 1'b0;
    alu_op          = 3'd0;
    alu_src2        = 1'b0;
    rd_src          = 1'b0;
    zero_ext        = 1'b0;
    except          = 1'b0;
    if (!reset) begin
      unique case (state_q)
        S_FETCH: imem_req = 1'b1;
        S_EXEC: begin
          alu_op   = dec_alu_op;
          alu_src2 = dec_src2;
          rd_src   = dec_rd_src;
          zero_ext = dec_zext;
        end
        S_WB: begin
          alu_op          = dec_alu_op;
          alu_src2        = dec_src2;
          rd_src          = dec_rd_src;
          zero_ext        = dec_zext;
          pc_enable       = 1'b1;
          rf_write_enable = 1'b1;
        end
        S_HALT:  except = 1'b1;
        default: imem_req = 1'b0;
      endcase
    end
  end

  assign retired = reset ? 16'd0 : retired_q;

endmodule

// File: tb/tb_arith_sequencer.sv
// Self-checking bench for arith_sequencer: vector table, corner-case sequences, randomized stream.
// Expected behaviour comes from an instruction table and a per-phase output model.
module tb_arith_sequencer;

  localparam int TO = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] inst;
  logic        imem_ack;
  logic        imem_req, pc_enable, rf_write_enable;
  logic [2:0]  alu_op;
  logic        alu_src2, rd_src, zero_ext, except_flag;
  logic [15:0] retired;

  arith_sequencer #(.ACK_TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .inst(inst), .imem_ack(imem_ack),
    .imem_req(imem_req), .pc_enable(pc_enable), .rf_write_enable(rf_write_enable),
    .alu_op(alu_op), .alu_src2(alu_src2), .rd_src(rd_src), .zero_ext(zero_ext),
    .except(except_flag), .retired(retired)
  );

  always #5 clock = ~clock;

  typedef struct { logic legal; logic [2:0] op; logic src2; logic rd; logic zx; } ctrl_t;
  typedef struct { logic [31:0] inst; int waits; ctrl_t exp; } vec_t;
  typedef struct { logic [5:0] opc; logic [5:0] fn; logic rtype; logic [2:0] op; logic zx; } isa_t;
  typedef struct {
    logic req; logic pce; logic rfwe; logic [2:0] op;
    logic src2; logic rd; logic zx; logic exc; logic [15:0] ret;
  } o_t;

  localparam int PH_FETCH = 0, PH_DECODE = 1, PH_EXEC = 2, PH_WB = 3, PH_HALT = 4, PH_RESET = 5;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_ret  = 16'd0;
  isa_t        isa[10];
  vec_t        vecs[$];
  bit          halted;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic ctrl_t ref_ctrl(input logic [31:0] w);
    ctrl_t c;
    c = '{legal: 1'b0, op: 3'd0, src2: 1'b0, rd: 1'b0, zx: 1'b0};
    foreach (isa[i]) begin
      if (isa[i].opc == w[31:26] && (!isa[i].rtype || isa[i].fn == w[5:0])) begin
        c.legal = 1'b1;
        c.op    = isa[i].op;
        c.src2  = !isa[i].rtype;
        c.rd    = !isa[i].rtype;
        c.zx    = isa[i].zx;
      end
    end
    return c;
  endfunction

  function automatic o_t o_phase(input int ph, input ctrl_t c);
    o_t e;
    e = '{req: 1'b0, pce: 1'b0, rfwe: 1'b0, op: 3'd0, src2: 1'b0, rd: 1'b0, zx: 1'b0,
          exc: 1'b0, ret: exp_ret};
    case (ph)
      PH_FETCH: e.req = 1'b1;
      PH_EXEC, PH_WB: begin
        e.op = c.op; e.src2 = c.src2; e.rd = c.rd; e.zx = c.zx;
        if (ph == PH_WB) begin e.pce = 1'b1; e.rfwe = 1'b1; end
      end
      PH_HALT:  e.exc = 1'b1;
      PH_RESET: e.ret = 16'd0;
      default:  e.req = 1'b0;
    endcase
    return e;
  endfunction

  task automatic check_outs(input string tag, input o_t e);
    chk({tag, ".imem_req"},        imem_req,        e.req);
    chk({tag, ".pc_enable"},       pc_enable,       e.pce);
    chk({tag, ".rf_write_enable"}, rf_write_enable, e.rfwe);
    chk({tag, ".alu_op"},          alu_op,          e.op);
    chk({tag, ".alu_src2"},        alu_src2,        e.src2);
    chk({tag, ".rd_src"},          rd_src,          e.rd);
    chk({tag, ".zero_ext"},        zero_ext,        e.zx);
    chk({tag, ".except"},          except_flag,     e.exc);
    chk({tag, ".retired"},         retired,         e.ret);
  endtask

  function automatic vec_t mk(input logic [31:0] w, input int waits, input logic legal,
                              input logic [2:0] op, input logic s2, input logic rd, input logic zx);
    vec_t v;
    v.inst = w; v.waits = waits;
    v.exp = '{legal: legal, op: op, src2: s2, rd: rd, zx: zx};
    return v;
  endfunction

  // Drives one instruction from a FETCH negedge. stop_at: 0 complete, PH_EXEC or PH_WB stop there.
  task automatic exec_instr(input logic [31:0] w, input int waits, input ctrl_t c,
                            input int stop_at, output bit hlt);
    hlt = 1'b0;
    for (int i = 0; i < waits && i < TO; i++) begin
      check_outs($sformatf("fetch_wait%0d", i), o_phase(PH_FETCH, c));
      imem_ack = 1'b0; inst = $urandom;
      @(negedge clock);
    end
    if (waits >= TO) begin
      check_outs("timeout_halt", o_phase(PH_HALT, c));
      hlt = 1'b1;
      return;
    end
    check_outs("fetch", o_phase(PH_FETCH, c));
    imem_ack = 1'b1; inst = w;
    @(negedge clock);
    check_outs($sformatf("decode_%08h", w), o_phase(PH_DECODE, c));
    imem_ack = 1'($urandom_range(0, 1)); inst = $urandom;
    @(negedge clock);
    if (!c.legal) begin
      check_outs($sformatf("illegal_halt_%08h", w), o_phase(PH_HALT, c));
      hlt = 1'b1;
      return;
    end
    check_outs($sformatf("exec_%08h", w), o_phase(PH_EXEC, c));
    if (stop_at == PH_EXEC) return;
    imem_ack = 1'($urandom_range(0, 1)); inst = $urandom;
    @(negedge clock);
    check_outs($sformatf("wb_%08h", w), o_phase(PH_WB, c));
    if (stop_at == PH_WB) return;
    imem_ack = 1'($urandom_range(0, 1)); inst = $urandom;
    @(negedge clock);
    exp_ret++;
    check_outs($sformatf("after_wb_%08h", w), o_phase(PH_FETCH, c));
  endtask

  task automatic hold_halt(input int n, input ctrl_t c);
    for (int i = 0; i < n; i++) begin
      check_outs($sformatf("halt_hold%0d", i), o_phase(PH_HALT, c));
      imem_ack = 1'($urandom_range(0, 1)); inst = $urandom;
      @(negedge clock);
    end
  endtask

  task automatic do_reset(input ctrl_t c);
    reset = 1'b1; imem_ack = 1'($urandom_range(0, 1)); inst = $urandom;
    #1 check_outs("during_reset", o_phase(PH_RESET, c));
    @(negedge clock);
    check_outs("reset_held", o_phase(PH_RESET, c));
    exp_ret = 16'd0;
    reset = 1'b0; imem_ack = 1'b0;
    #1 check_outs("after_reset", o_phase(PH_FETCH, c));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    ctrl_t     nc;
    ctrl_t     c;
    logic [31:0] w;
    int        waits;
    isa_t      pick;

    nc = '{legal: 1'b0, op: 3'd0, src2: 1'b0, rd: 1'b0, zx: 1'b0};
    isa[0] = '{opc: 6'h00, fn: 6'h20, rtype: 1'b1, op: 3'd2, zx: 1'b0};
    isa[1] = '{opc: 6'h00, fn: 6'h22, rtype: 1'b1, op: 3'd3, zx: 1'b0};
    isa[2] = '{opc: 6'h00, fn: 6'h24, rtype: 1'b1, op: 3'd4, zx: 1'b0};
    isa[3] = '{opc: 6'h00, fn: 6'h25, rtype: 1'b1, op: 3'd5, zx: 1'b0};
    isa[4] = '{opc: 6'h00, fn: 6'h26, rtype: 1'b1, op: 3'd7, zx: 1'b0};
    isa[5] = '{opc: 6'h00, fn: 6'h27, rtype: 1'b1, op: 3'd6, zx: 1'b0};
    isa[6] = '{opc: 6'h08, fn: 6'h00, rtype: 1'b0, op: 3'd2, zx: 1'b0};
    isa[7] = '{opc: 6'h0c, fn: 6'h00, rtype: 1'b0, op: 3'd4, zx: 1'b1};
    isa[8] = '{opc: 6'h0d, fn: 6'h00, rtype: 1'b0, op: 3'd5, zx: 1'b1};
    isa[9] = '{opc: 6'h0e, fn: 6'h00, rtype: 1'b0, op: 3'd7, zx: 1'b1};

    vecs.push_back(mk(32'h00853020, 0, 1, 3'd2, 0, 0, 0)); // add
    vecs.push_back(mk(32'h3482FFFF, 0, 1, 3'd5, 1, 1, 1)); // ori
    vecs.push_back(mk(32'h2082FFFF, 0, 1, 3'd2, 1, 1, 0)); // addi
    vecs.push_back(mk(32'h00853022, 2, 1, 3'd3, 0, 0, 0)); // sub
    vecs.push_back(mk(32'h00853024, 1, 1, 3'd4, 0, 0, 0)); // and
    vecs.push_back(mk(32'h00853025, 7, 1, 3'd5, 0, 0, 0)); // or, ack on last allowed cycle
    vecs.push_back(mk(32'h00853026, 3, 1, 3'd7, 0, 0, 0)); // xor
    vecs.push_back(mk(32'h00853027, 0, 1, 3'd6, 0, 0, 0)); // nor
    vecs.push_back(mk(32'h30821234, 5, 1, 3'd4, 1, 1, 1)); // andi
    vecs.push_back(mk(32'h38828000, 4, 1, 3'd7, 1, 1, 1)); // xori
    vecs.push_back(mk(32'h00853021, 0, 0, 3'd0, 0, 0, 0)); // unsupported funct
    vecs.push_back(mk(32'h24820001, 1, 0, 3'd0, 0, 0, 0)); // unsupported opcode
    vecs.push_back(mk(32'hFC000000, 0, 0, 3'd0, 0, 0, 0));

    reset = 1'b1; imem_ack = 1'b0; inst = 32'd0;
    @(negedge clock);
    do_reset(nc);

    foreach (vecs[i]) begin
      exec_instr(vecs[i].inst, vecs[i].waits, vecs[i].exp, 0, halted);
      chk($sformatf("vec%0d_halted", i), {31'd0, halted}, {31'd0, !vecs[i].exp.legal});
      if (halted) begin
        hold_halt(3, nc);
        do_reset(nc);
      end
    end

    // Fetch timeout with no ack at all, then held fault.
    exec_instr(32'h00853020, TO, nc, 0, halted);
    chk("timeout_halted", {31'd0, halted}, 32'd1);
    hold_halt(20, nc);
    do_reset(nc);

    // Illegal instruction after some retirements: fault holds, count frozen.
    exec_instr(32'h00853020, 0, ref_ctrl(32'h00853020), 0, halted);
    exec_instr(32'h3482FFFF, 1, ref_ctrl(32'h3482FFFF), 0, halted);
    exec_instr(32'hFC000000, 0, nc, 0, halted);
    hold_halt(20, nc);
    do_reset(nc);

    // Reset coincident with WB does not count the instruction.
    exec_instr(32'h00853020, 0, ref_ctrl(32'h00853020), 0, halted);
    exec_instr(32'h00853020, 0, ref_ctrl(32'h00853020), PH_WB, halted);
    do_reset(nc);
    chk("wb_reset_retired", retired, 16'd0);

    // Reset during EXEC of sub: no writeback, back to fetch.
    exec_instr(32'h00853022, 0, ref_ctrl(32'h00853022), PH_EXEC, halted);
    reset = 1'b1;
    #1 chk("exec_reset_rfwe", rf_write_enable, 1'b0);
    chk("exec_reset_pce", pc_enable, 1'b0);
    @(negedge clock);
    chk("exec_reset_rfwe_next", rf_write_enable, 1'b0);
    exp_ret = 16'd0;
    reset = 1'b0; imem_ack = 1'b0;
    #1 check_outs("exec_reset_fetch", o_phase(PH_FETCH, nc));
    exec_instr(32'h00853022, 0, ref_ctrl(32'h00853022), 0, halted);

    // Retired counter wrap.
    force dut.retired_q = 16'hFFFF;
    #1 release dut.retired_q;
    exp_ret = 16'hFFFF;
    chk("preload_retired", retired, 16'hFFFF);
    exec_instr(32'h00853020, 0, ref_ctrl(32'h00853020), 0, halted);
    chk("wrap_retired", retired, 16'h0000);

    // Randomized stream against the instruction-table model.
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        w = $urandom;
      end else begin
        pick = isa[$urandom_range(0, 9)];
        w = $urandom;
        w[31:26] = pick.opc;
        if (pick.rtype) w[5:0] = pick.fn;
      end
      waits = ($urandom_range(0, 9) == 0) ? TO : int'($urandom_range(0, TO - 1));
      c = ref_ctrl(w);
      exec_instr(w, waits, c, 0, halted);
      chk($sformatf("rand%0d_halted", n), {31'd0, halted},
          {31'd0, (waits >= TO) || !c.legal});
      if (halted) begin
        hold_halt(int'($urandom_range(1, 4)), nc);
        do_reset(nc);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/arith_sequencer.md
ARITH_SEQUENCER -- requirements
Module: arith_sequencer

Interface
REQ-001 The block SHALL have parameter ACK_TIMEOUT, default 8, meaning the maximum cycles FETCH waits for imem_ack before faulting (legal range 1..255).
REQ-002 The block SHALL have port clock  input  1  sole clock, all state updates on its rising edge.
REQ-003 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have port inst  input  32  instruction word, valid when imem_ack=1.
REQ-005 The block SHALL have port imem_ack  input  1  instruction memory has inst valid this cycle.
REQ-006 The block SHALL have port imem_req  output  1  request instruction at current PC.
REQ-007 The block SHALL have port pc_enable  output  1  PC register write enable (PC <- PC+4).
REQ-008 The block SHALL have port rf_write_enable  output  1  register file write enable.
REQ-009 The block SHALL have port alu_op  output  3  ALU operation: add=2, sub=3, and=4, or=5, nor=6, xor=7.
REQ-010 The block SHALL have port alu_src2  output  1  0 = rt data, 1 = extended immediate.
REQ-011 The block SHALL have port rd_src  output  1  write register: 0 = rd field, 1 = rt field.
REQ-012 The block SHALL have port zero_ext  output  1  1 = zero-extend imm16, 0 = sign-extend.
REQ-013 The block SHALL have port except  output  1  sticky fault flag.
REQ-014 The block SHALL have port retired  output  16  count of completed instructions.

Function
REQ-015 The FSM SHALL have states FETCH, DECODE, EXEC, WB, HALT; reset enters FETCH.
REQ-016 FETCH SHALL assert imem_req=1; on imem_ack=1 it SHALL latch inst[31:26] (opcode) and inst[5:0] (funct) into internal registers and go to DECODE next cycle.
REQ-017 FETCH SHALL count wait cycles without ack; when the count reaches ACK_TIMEOUT with imem_ack=0 it SHALL go to HALT; ack in the same cycle the count reaches ACK_TIMEOUT SHALL win (normal fetch).
REQ-018 DECODE SHALL go to EXEC for legal instructions, else HALT; legal set: opcode 0x00 with funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x26 xor, 0x27 nor; opcode 0x08 addi, 0x0c andi, 0x0d ori, 0x0e xori.
REQ-019 EXEC SHALL unconditionally go to WB; WB SHALL go to FETCH.
REQ-020 alu_op, alu_src2, rd_src, zero_ext SHALL be decoded combinationally from latched fields and held valid in EXEC and WB; R-type: alu_src2=0, rd_src=0; I-type: alu_src2=1, rd_src=1; zero_ext=1 only for andi/ori/xori.
REQ-021 Outside EXEC/WB the four control outputs SHALL be 0 (alu_op=0).
REQ-022 rf_write_enable and pc_enable SHALL be 1 for exactly one cycle, in WB only.
REQ-023 retired SHALL increment by 1 on each WB cycle, wrapping 0xFFFF -> 0x0000.
REQ-024 HALT SHALL be absorbing until reset: except=1, imem_req=0, all enables 0, retired frozen.
REQ-025 except SHALL be 1 only in HALT and rise on the cycle HALT is entered.
REQ-026 Latency SHALL be 4 cycles per instruction when imem_ack is high on the first FETCH cycle; each extra FETCH wait cycle adds 1.
REQ-027 imem_ack outside FETCH SHALL be ignored; inst SHALL not be sampled outside FETCH.

Reset
REQ-028 reset=1 at a rising edge SHALL, in any state including mid-instruction and HALT, force FETCH, clear except, retired, timeout counter, latched opcode/funct.
REQ-029 A WB cycle coincident with reset SHALL NOT increment retired; during reset all outputs SHALL be their idle values (imem_req driven per FETCH only after reset deasserts).
REQ-030 Outputs after reset: imem_req=1, pc_enable=0, rf_write_enable=0, alu_op=0, alu_src2=0, rd_src=0, zero_ext=0, except=0, retired=0.

Verification
REQ-031 add (0x00853020), ack held 1 -> FETCH,DECODE,EXEC,WB; WB: alu_op=2, alu_src2=0, rd_src=0, rf_write_enable=1, pc_enable=1; retired=1.
REQ-032 ori 0x3482FFFF then addi 0x2082FFFF -> ori: alu_op=5, alu_src2=1, rd_src=1, zero_ext=1; addi: alu_op=2, zero_ext=0; retired=2 after 8 cycles.
REQ-033 Illegal 0xFC000000 -> HALT entered after DECODE, except=1 and held 20 cycles, no rf_write_enable pulse, retired unchanged; reset -> except=0, FETCH.
REQ-034 ACK_TIMEOUT=8, imem_ack=0 for 8 cycles -> HALT, except=1; repeat with ack on 8th cycle -> normal DECODE.
REQ-035 Preload 65535 retirements (or force) then one more add -> retired=0x0000.
REQ-036 reset asserted during EXEC of sub (funct 0x22) -> no write-enable pulse, retired=0, next state FETCH.
